// File: rtl/block_word_writer_if.sv
// Handshake/bus bundle for block_word_writer: base-block load, word writes, flush and merged-block output.
interface block_word_writer_if #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512
);
  localparam int WORDS  = BLOCK_DATA_WIDTH / WORD_SIZE;
  localparam int OFF_W  = $clog2(WORDS);
  localparam int STRB_W = WORD_SIZE / 8;

  logic                        load_valid;
  logic                        load_ready;
  logic [BLOCK_DATA_WIDTH-1:0] load_block;
  logic                        wr_valid;
  logic                        wr_ready;
  logic [OFF_W-1:0]            wr_offset;
  logic [WORD_SIZE-1:0]        wr_data;
  logic [STRB_W-1:0]           wr_strb;
  logic                        flush_req;
  logic                        out_valid;
  logic                        out_ready;
  logic [BLOCK_DATA_WIDTH-1:0] out_block;
  logic [WORDS-1:0]            out_dirty_mask;
  logic                        busy;

  modport master (
    output load_valid, load_block, wr_valid, wr_offset, wr_data, wr_strb, flush_req, out_ready,
    input  load_ready, wr_ready, out_valid, out_block, out_dirty_mask, busy
  );

  modport slave (
    input  load_valid, load_block, wr_valid, wr_offset, wr_data, wr_strb, flush_req, out_ready,
    output load_ready, wr_ready, out_valid, out_block, out_dirty_mask, busy
  );
endinterface

// File: rtl/block_word_writer.sv
// Merges byte-strobed store words into a cache block and emits it with a dirty mask on flush.
// Optional macro BLOCK_WORD_WRITER_SKIP_CLEAN_EN: a flush of an unmodified block returns to IDLE without output.
module block_word_writer #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_DATA_WIDTH = 512
) (
  input logic               clk,
  input logic               rst_n,
  block_word_writer_if.slave bus
);
  localparam int WORDS  = BLOCK_DATA_WIDTH / WORD_SIZE;
  localparam int STRB_W = WORD_SIZE / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OPEN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  w_next;
  logic [BLOCK_DATA_WIDTH-1:0] r_buf;
  logic [WORDS-1:0]            r_mask;
  logic [WORD_SIZE-1:0]        w_old_word;
  logic [WORD_SIZE-1:0]        w_new_word;
  logic                        w_wr_fire;
  logic                        w_wr_dirty;
  logic                        w_skip;
  int                          w_base;

  assign w_base     = int'(bus.wr_offset) * WORD_SIZE;
  assign w_wr_fire  = (r_state == S_OPEN) && bus.wr_valid;
  assign w_wr_dirty = w_wr_fire && (bus.wr_strb != '0);
  assign w_old_word = r_buf[w_base +: WORD_SIZE];

  always_comb begin
    // NOTE: default first so every path assigns the word and no latch is inferred.
    w_new_word = w_old_word;
    for (int b = 0; b < STRB_W; b++) begin
      if (bus.wr_strb[b]) w_new_word[b*8 +: 8] = bus.wr_data[b*8 +: 8];
    end
  end

`ifdef BLOCK_WORD_WRITER_SKIP_CLEAN_EN
  assign w_skip = (r_mask == '0) && !w_wr_dirty;
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.load_valid) w_next = S_OPEN;
      S_OPEN:  if (bus.flush_req)  w_next = w_skip ? S_IDLE : S_DRAIN;
      S_DRAIN: if (bus.out_ready)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the block buffer drives out_block directly, so it is reset along with the control state.
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_mask  <= '0;
    end else begin
      // NOTE: non-blocking updates keep every register reading pre-edge values.
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.load_valid) begin
            r_buf  <= bus.load_block;
            r_mask <= '0;
          end
        end
        S_OPEN: begin
          if (w_wr_fire) r_buf[w_base +: WORD_SIZE] <= w_new_word;
          if (w_wr_dirty) r_mask[bus.wr_offset] <= 1'b1;
        end
        S_DRAIN: begin
          if (bus.out_ready) r_mask <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready     = (r_state == S_IDLE);
  assign bus.wr_ready       = (r_state == S_OPEN);
  assign bus.out_valid      = (r_state == S_DRAIN);
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.out_block      = r_buf;
  assign bus.out_dirty_mask = r_mask;
endmodule

// File: tb/tb_block_word_writer.sv
// Scoreboard bench for block_word_writer: random loads/writes/flushes against a word-array reference model.
module tb_block_word_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  block_word_writer_if bus ();
  block_word_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [511:0] blk;
    logic [15:0]  mask;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_words[16];
  logic [15:0] m_mask;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] pack_model();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = m_words[i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [511:0] blk);
    int n = 0;
    while (!bus.load_ready && n < 50) begin tick(); n++; end
    check("load_ready", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.load_block = blk;
    tick();
    bus.load_valid = 1'b0;
    for (int i = 0; i < 16; i++) m_words[i] = blk[i*32 +: 32];
    m_mask = '0;
    check("wr_ready_after_load", bus.wr_ready, 1);
  endtask

  // Reference model: per-byte replace, dirty if any strobe set.
  task automatic model_write(input int off, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        m_words[off] = (m_words[off] & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
      end
    end
    if (strb != 4'h0) m_mask[off] = 1'b1;
  endtask

  // Returns 1 if the block is expected to be presented.
  task automatic predict_flush(output bit drains);
`ifdef BLOCK_WORD_WRITER_SKIP_CLEAN_EN
    drains = (m_mask != 16'h0);
`else
    drains = 1'b1;
`endif
    if (drains) begin
      sb_q.push_back('{blk: pack_model(), mask: m_mask});
      check("flush_latency_valid", bus.out_valid, 1);
    end else begin
      check("skip_clean_valid", bus.out_valid, 0);
      check("skip_clean_busy", bus.busy, 0);
    end
  endtask

  task automatic do_write(input int off, input logic [31:0] data, input logic [3:0] strb,
                          input bit flush, output bit drains);
    bus.wr_valid  = 1'b1;
    bus.wr_offset = off[3:0];
    bus.wr_data   = data;
    bus.wr_strb   = strb;
    bus.flush_req = flush;
    tick();
    bus.wr_valid  = 1'b0;
    bus.flush_req = 1'b0;
    model_write(off, data, strb);
    drains = 1'b0;
    if (flush) predict_flush(drains);
  endtask

  task automatic do_flush(output bit drains);
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    predict_flush(drains);
  endtask

  task automatic drain(input int stall);
    int n = 0;
    bus.out_ready = 1'b0;
    repeat (stall) tick();
    bus.out_ready = 1'b1;
    do begin tick(); n++; end while (bus.out_valid && n < 20);
    check("drain_done", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output got=block_presented want=none");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_block", bus.out_block, e.blk);
        check("out_dirty_mask", bus.out_dirty_mask, e.mask);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           dr;
    logic [511:0] blk;
    bus.load_valid = 0; bus.load_block = '0; bus.wr_valid = 0; bus.wr_offset = '0;
    bus.wr_data = '0; bus.wr_strb = '0; bus.flush_req = 0; bus.out_ready = 0;

    #12;
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_mask", bus.out_dirty_mask, 16'h0000);
    check("rst_block", bus.out_block, '0);
    rst_n = 1'b1;
    tick();

    // Two writes into an 0xAA block, then flush.
    blk = {16{32'hAAAAAAAA}};
    do_load(blk);
    do_write(0, 32'h12345678, 4'b1111, 0, dr);
    do_write(15, 32'hDEADBEEF, 4'b0011, 0, dr);
    do_flush(dr);
    check("basic_word0", bus.out_block[31:0], 32'h12345678);
    check("basic_word15", bus.out_block[511:480], 32'hAAAABEEF);
    check("basic_word7", bus.out_block[255:224], 32'hAAAAAAAA);
    check("basic_mask", bus.out_dirty_mask, 16'h8001);
    drain(0);

    // Write and flush in the same cycle, then stall in DRAIN with other requests offered.
    do_load({16{32'h5A5A5A5A}});
    do_write(7, 32'h0BADF00D, 4'hF, 1, dr);
    check("cowrite_word7", bus.out_block[255:224], 32'h0BADF00D);
    check("cowrite_mask7", bus.out_dirty_mask[7], 1);
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid = 1'b1; bus.wr_offset = 4'd3; bus.wr_data = 32'hFFFFFFFF; bus.wr_strb = 4'hF;
      bus.load_valid = 1'b1; bus.load_block = '1;
      tick();
      check("stall_valid", bus.out_valid, 1);
      check("stall_wr_ready", bus.wr_ready, 0);
      check("stall_load_ready", bus.load_ready, 0);
      check("stall_block", bus.out_block, pack_model());
      check("stall_mask", bus.out_dirty_mask, m_mask);
    end
    bus.wr_valid = 1'b0; bus.load_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("stall_release_valid", bus.out_valid, 0);
    check("stall_release_idle", bus.load_ready, 1);
    check("stall_release_keep_block", bus.out_block, pack_model());
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of an open block.
    do_load({16{32'h11111111}});
    do_write(2, 32'hCAFEF00D, 4'hF, 0, dr);
    do_write(9, 32'h01020304, 4'b0101, 0, dr);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_load_ready", bus.load_ready, 1);
    check("midrst_wr_ready", bus.wr_ready, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_mask", bus.out_dirty_mask, 16'h0000);
    check("midrst_block", bus.out_block, '0);
    #3 rst_n = 1'b1;
    tick();
    do_load({16{32'h22222222}});
    check("postrst_busy", bus.busy, 1);

    // Flush without writes: clean block.
    do_flush(dr);
    if (dr) begin
      check("clean_mask", bus.out_dirty_mask, 16'h0000);
      drain(1);
    end

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      int nw;
      for (int i = 0; i < 16; i++) blk[i*32 +: 32] = $urandom;
      do_load(blk);
      nw = $urandom_range(0, 6);
      dr = 1'b0;
      for (int w = 0; w < nw; w++) begin
        logic [3:0] s;
        s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
        do_write($urandom_range(0, 15), $urandom, s, (w == nw - 1) && $urandom_range(0, 1) == 1, dr);
        if (!bus.wr_ready) break;
      end
      if (bus.wr_ready) do_flush(dr);
      if (dr) drain($urandom_range(0, 3));
    end

    tick();
    check("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
